// File: rtl/boot_copy_pkg.sv
// Shared definitions for the boot copy controller: FSM encoding and the
// boot-control word written at the end of the copy.
package boot_copy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_CTRL_WR,
        ST_DONE
    } state_t;

    localparam int BOOT_BIT    = 0;
    localparam int CPU_RST_BIT = 1;

    // boot = 0 (leave boot mode), cpu_reset = 1 (fire the CPU reset pulse)
    localparam logic [1:0] CTRL_WORD = 2'((1 << CPU_RST_BIT) | (0 << BOOT_BIT));

endpackage

// File: rtl/boot_copy_csum.sv
// Wrapping sum of every word read from the boot image. Cleared when a new copy
// starts; only instantiated when BOOT_COPY_CSUM_EN is defined.
module boot_copy_csum
    import boot_copy_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] sum_q;

    // Accumulator: clear has priority over add; cke_i freezes the sum
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sum_q <= '0;
        end else if (cke_i) begin
            if (clr_i) begin
                sum_q <= '0;
            end else if (en_i) begin
                sum_q <= sum_q + data_i;
            end
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/boot_copy_ctr.sv
// IOb-bus initiator that copies the boot image word by word, then writes the
// boot-control register to leave boot mode and release the CPU.
// Optional build macro: BOOT_COPY_CSUM_EN enables image checksum verification;
// on mismatch the control write is skipped and err_o is set.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start_i; src/dst/len latched on start
// ST_RD_REQ  | read request to src pointer, held until accepted
// ST_RD_WAIT | single outstanding read; capture rdata on rvalid
// ST_WR_REQ  | write of captured word to dst pointer, held until accepted
// ST_CTRL_WR | write CTRL_WORD to the boot-control register
// ST_DONE    | one-cycle done pulse, back to idle
module boot_copy_ctr
    import boot_copy_pkg::*;
#(
    parameter int              ADDR_W        = 32,
    parameter int              DATA_W        = 32,
    parameter int              STRB_W        = DATA_W / 8,
    parameter int              LEN_W         = 16,
    parameter logic [ADDR_W-1:0] BOOT_CTR_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] csum_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              iob_avalid_o,
    output logic [ADDR_W-1:0] iob_addr_o,
    output logic [DATA_W-1:0] iob_wdata_o,
    output logic [STRB_W-1:0] iob_wstrb_o,
    input  logic              iob_rvalid_i,
    input  logic [DATA_W-1:0] iob_rdata_i,
    input  logic              iob_ready_i
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              sum_clr, sum_en;
    logic              csum_ok;

`ifdef BOOT_COPY_CSUM_EN
    logic [DATA_W-1:0] csum_sum;

    boot_copy_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .clr_i  (sum_clr),
        .en_i   (sum_en),
        .data_i (iob_rdata_i),
        .sum_o  (csum_sum)
    );

    // With len==0 the check happens on the start cycle, before the clear lands
    assign csum_ok = (((state_q == ST_IDLE) ? '0 : csum_sum) == csum_i);
`else
    logic unused_csum;
    assign unused_csum = ^{csum_i, sum_clr, sum_en};
    assign csum_ok     = 1'b1;
`endif

    // State and datapath registers; cke_i low holds everything
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath updates and bus outputs
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        err_d        = err_q;
        sum_clr      = 1'b0;
        sum_en       = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        iob_avalid_o = 1'b0;
        iob_addr_o   = '0;
        iob_wdata_o  = '0;
        iob_wstrb_o  = '0;

        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    len_d   = len_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    sum_clr = 1'b1;
                    if (len_i != '0) begin
                        state_d = ST_RD_REQ;
                    end else if (csum_ok) begin
                        state_d = ST_CTRL_WR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = src_q;
                if (iob_ready_i) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (iob_rvalid_i) begin
                    data_d  = iob_rdata_i;
                    sum_en  = 1'b1;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = dst_q;
                iob_wdata_o  = data_q;
                iob_wstrb_o  = '1;
                if (iob_ready_i) begin
                    src_d = src_q + ADDR_W'(STRB_W);
                    dst_d = dst_q + ADDR_W'(STRB_W);
                    cnt_d = cnt_q + LEN_W'(1);
                    if ((cnt_q + LEN_W'(1)) < len_q) begin
                        state_d = ST_RD_REQ;
                    end else if (csum_ok) begin
                        state_d = ST_CTRL_WR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CTRL_WR: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = BOOT_CTR_ADDR;
                iob_wdata_o  = DATA_W'(CTRL_WORD);
                iob_wstrb_o  = '1;
                if (iob_ready_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_boot_copy_ctr.sv
// Bench for boot_copy_ctr: a slave model answers the IOb bus, stimulus pushes
// the expected request sequence into a queue, and a monitor pops and compares
// every accepted request and every done pulse.
module tb_boot_copy_ctr;

    logic        clk_i = 1'b0;
    logic        cke_i = 1'b1;
    logic        arst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic [31:0] csum_i = '0;
    logic        busy_o, done_o, err_o;
    logic        iob_avalid_o;
    logic [31:0] iob_addr_o, iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_rvalid_i;
    logic [31:0] iob_rdata_i;
    logic        iob_ready_i;

    boot_copy_ctr dut (
        .clk_i        (clk_i),
        .cke_i        (cke_i),
        .arst_i       (arst_i),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
        .csum_i       (csum_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .iob_avalid_o (iob_avalid_o),
        .iob_addr_o   (iob_addr_o),
        .iob_wdata_o  (iob_wdata_o),
        .iob_wstrb_o  (iob_wstrb_o),
        .iob_rvalid_i (iob_rvalid_i),
        .iob_rdata_i  (iob_rdata_i),
        .iob_ready_i  (iob_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    bit   rom_sel = 1'b0;
    bit   stall_mode = 1'b0;

    localparam logic [31:0] IMG_SUM = 32'h347BC252;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (rom_sel) return (a >> 2) + 32'd1;
        case (a[3:2])
            2'd0:    return 32'hDEADBEEF;
            2'd1:    return 32'h01234567;
            2'd2:    return 32'hCAFEF00D;
            default: return 32'h89ABCDEF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = addr;
        e.wdata   = wdata;
        e.wstrb   = wstrb;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.wdata   = '0;
        e.wstrb   = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input bit ctrl);
        for (int i = 0; i < len; i++) begin
            push_req(src + 32'(4 * i), 32'h0, 4'h0);
            push_req(dst + 32'(4 * i), rom(src + 32'(4 * i)), 4'hF);
        end
        if (ctrl) push_req(32'h0, 32'h2, 4'hF);
        push_done();
    endtask

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                              input logic [15:0] len, input logic [31:0] csum);
        @(posedge clk_i); #2;
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = len;
        csum_i     = csum;
        start_i    = 1'b1;
        @(posedge clk_i); #2;
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        int d0;
        d0 = done_cnt;
        cycles = 0;
        while (done_cnt == d0 && cycles < budget) begin
            @(posedge clk_i);
            cycles++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_timeout got=no_done exp=done within %0d cycles", name, budget);
        end
    endtask

    task automatic post_check(input string name, input logic exp_err);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #3;
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy"}, 32'(busy_o), 32'd0);
        check({name, "_err"}, 32'(err_o), 32'(exp_err));
        exp_q.delete();
    endtask

    // Slave: decides ready/rvalid on the falling edge for the next rising edge
    int          stall_left = 0;
    bit          rd_pend = 1'b0;
    int          rd_delay = 0;
    logic [31:0] rd_addr = '0;
    bit          held = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;

    initial begin
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        iob_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            if (arst_i) begin
                iob_ready_i  = 1'b0;
                iob_rvalid_i = 1'b0;
                rd_pend      = 1'b0;
                held         = 1'b0;
                stall_left   = 0;
                continue;
            end
            if (!cke_i) continue;
            iob_rvalid_i = 1'b0;
            if (rd_pend) begin
                if (rd_delay == 0) begin
                    iob_rvalid_i = 1'b1;
                    iob_rdata_i  = rom(rd_addr);
                    rd_pend      = 1'b0;
                end else begin
                    rd_delay--;
                end
            end else if (stall_mode && $urandom_range(0, 3) == 0) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = 32'hBAD0BAD0;
            end
            if (held) begin
                checks++;
                if (!iob_avalid_o || iob_addr_o !== h_addr || iob_wdata_o !== h_wdata || iob_wstrb_o !== h_wstrb) begin
                    errors++;
                    $display("FAIL stall_stable got=%b/%h/%h/%h exp=1/%h/%h/%h", iob_avalid_o,
                             iob_addr_o, iob_wdata_o, iob_wstrb_o, h_addr, h_wdata, h_wstrb);
                end
            end
            held        = 1'b0;
            iob_ready_i = 1'b0;
            if (iob_avalid_o) begin
                if (stall_left > 0) begin
                    stall_left--;
                    held    = 1'b1;
                    h_addr  = iob_addr_o;
                    h_wdata = iob_wdata_o;
                    h_wstrb = iob_wstrb_o;
                end else begin
                    iob_ready_i = 1'b1;
                    if (iob_wstrb_o == 4'h0) begin
                        rd_pend  = 1'b1;
                        rd_addr  = iob_addr_o;
                        rd_delay = stall_mode ? int'($urandom_range(0, 3)) : 0;
                    end
                    stall_left = stall_mode ? int'($urandom_range(0, 5)) : 0;
                end
            end
        end
    end

    // Monitor: compares each accepted request and done pulse with the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i); #3;
            if (!arst_i && cke_i) begin
                if (iob_avalid_o && iob_ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL bus_req got=%h/%h/%h exp=no request", iob_addr_o, iob_wdata_o, iob_wstrb_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_done || iob_addr_o !== e.addr || iob_wstrb_o !== e.wstrb ||
                            (e.wstrb != 4'h0 && iob_wdata_o !== e.wdata)) begin
                            errors++;
                            $display("FAIL bus_req got=%h/%h/%h exp=%h/%h/%h done=%0d", iob_addr_o, iob_wdata_o,
                                     iob_wstrb_o, e.addr, e.wdata, e.wstrb, e.is_done);
                        end
                    end
                    if (iob_wstrb_o != 4'h0) wr_cnt++;
                end
                if (done_o) begin
                    done_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_pulse got=done exp=nothing");
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_done) begin
                            errors++;
                            $display("FAIL done_pulse got=done exp=request %h/%h", e.addr, e.wdata);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int wc0;
        int n;

        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_avalid", 32'(iob_avalid_o), 32'd0);
        check("rst_addr", iob_addr_o, 32'd0);
        check("rst_wstrb", 32'(iob_wstrb_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #2 arst_i = 1'b0;

        // 1: zero-wait copy of 4 words, 3 cycles per word plus ctrl and done
        push_copy(32'h0, 32'h1000, 4, 1'b1);
        start_copy(32'h0, 32'h1000, 16'd4, IMG_SUM);
        wait_done("t1", 100, cyc);
        check("t1_latency", 32'(cyc), 32'd14);
        post_check("t1", 1'b0);

        // 2: len=0 goes straight to the control write
        push_copy(32'h0, 32'h0, 0, 1'b1);
        start_copy(32'h40, 32'h2000, 16'd0, 32'h0);
        wait_done("t2", 50, cyc);
        check("t2_latency", 32'(cyc), 32'd2);
        post_check("t2", 1'b0);

        // 3: random ready stalls, rvalid delays and stray rvalid pulses
        stall_mode = 1'b1;
        push_copy(32'h0, 32'h1000, 4, 1'b1);
        start_copy(32'h0, 32'h1000, 16'd4, IMG_SUM);
        wait_done("t3", 400, cyc);
        post_check("t3", 1'b0);
        stall_mode = 1'b0;

        // 4: reset after two words aborts at once; a fresh start copies everything
        wc0 = wr_cnt;
        push_copy(32'h0, 32'h1000, 4, 1'b1);
        start_copy(32'h0, 32'h1000, 16'd4, IMG_SUM);
        n = 0;
        while (wr_cnt < wc0 + 2 && n < 100) begin
            @(negedge clk_i); #4;
            n++;
        end
        check("t4_two_words", 32'(wr_cnt - wc0), 32'd2);
        @(posedge clk_i); #2;
        arst_i = 1'b1;
        exp_q.delete();
        #1;
        check("t4_rst_avalid", 32'(iob_avalid_o), 32'd0);
        check("t4_rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i); #2;
        arst_i = 1'b0;
        push_copy(32'h0, 32'h1000, 4, 1'b1);
        start_copy(32'h0, 32'h1000, 16'd4, IMG_SUM);
        wait_done("t4", 100, cyc);
        post_check("t4", 1'b0);

        // 5: checksum words 1,2,3
        rom_sel = 1'b1;
`ifdef BOOT_COPY_CSUM_EN
        push_copy(32'h0, 32'h3000, 3, 1'b1);
        start_copy(32'h0, 32'h3000, 16'd3, 32'd6);
        wait_done("t5a", 100, cyc);
        post_check("t5a", 1'b0);
        push_copy(32'h0, 32'h3000, 3, 1'b0);
        start_copy(32'h0, 32'h3000, 16'd3, 32'd7);
        wait_done("t5b", 100, cyc);
        post_check("t5b", 1'b1);
        push_copy(32'h0, 32'h0, 0, 1'b1);
        start_copy(32'h0, 32'h3000, 16'd0, 32'd0);
        wait_done("t5c", 50, cyc);
        post_check("t5c", 1'b0);
`else
        push_copy(32'h0, 32'h3000, 3, 1'b1);
        start_copy(32'h0, 32'h3000, 16'd3, 32'd7);
        wait_done("t5", 100, cyc);
        post_check("t5", 1'b0);
`endif
        rom_sel = 1'b0;

        // 6: destination wraps; start while busy is ignored; cke low freezes
        push_req(32'h20, 32'h0, 4'h0);
        push_req(32'hFFFFFFFC, 32'hDEADBEEF, 4'hF);
        push_req(32'h24, 32'h0, 4'h0);
        push_req(32'h00000000, 32'h01234567, 4'hF);
        push_req(32'h0, 32'h2, 4'hF);
        push_done();
        start_copy(32'h20, 32'hFFFFFFFC, 16'd2, 32'hDFD10456);
        repeat (4) @(posedge clk_i);
        #2;
        src_addr_i = 32'h40;
        dst_addr_i = 32'h2000;
        len_i      = 16'd5;
        start_i    = 1'b1;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        @(posedge clk_i); #2;
        cke_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #3;
        check("t6_frz_avalid", 32'(iob_avalid_o), 32'd1);
        check("t6_frz_addr", iob_addr_o, 32'h0);
        check("t6_frz_wdata", iob_wdata_o, 32'h2);
        check("t6_frz_busy", 32'(busy_o), 32'd1);
        @(posedge clk_i); #2;
        cke_i = 1'b1;
        wait_done("t6", 50, cyc);
        post_check("t6", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
